// File: rtl/inc_pkg.sv
// Purpose: shared constants and helpers for the step counter datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inc_pkg;

  // Direction encoding on the Dir input.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Values of the SATURATE parameter.
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Mask with the low 'width' bits set; callers size-cast to their own width.
  function automatic logic [63:0] all_ones(input int width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/inc_step_alu.sv
// Purpose: combinational add/subtract of a zero-extended step with carry/borrow detect.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   a     in  DATAWIDTH  current count
//   step  in  STEPWIDTH  unsigned step magnitude
//   dir   in  1          1 = add, 0 = subtract
//   r     out DATAWIDTH  low DATAWIDTH bits of the result
//   evt   out 1          carry out (up) or borrow out (down)
module inc_step_alu
  import inc_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int STEPWIDTH = 4
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [STEPWIDTH-1:0] step,
  input  logic                 dir,
  output logic [DATAWIDTH-1:0] r,
  output logic                 evt
);

  // One extra bit on top: for an add it catches the carry, for a subtract
  // it goes high exactly when step > a (two's-complement borrow).
  logic [DATAWIDTH:0] a_ext;
  logic [DATAWIDTH:0] step_ext;
  logic [DATAWIDTH:0] sum;

  assign a_ext    = {1'b0, a};
  assign step_ext = {{(DATAWIDTH + 1 - STEPWIDTH){1'b0}}, step};

  always_comb begin
    sum = '0;
    if (dir == DIR_UP) begin
      sum = a_ext + step_ext;
    end else begin
      sum = a_ext - step_ext;
    end
  end

  assign r   = sum[DATAWIDTH-1:0];
  assign evt = sum[DATAWIDTH];

endmodule

// File: rtl/inc_step_counter.sv
// Purpose: registered up/down counter with runtime step, load/clear, wrap or saturate, sticky overflow.
// Latency: 1 cycle from sampling edge to d; tc is combinational from d and Dir.
// Backpressure: none; accepts one operation per cycle (Rst > Clr > Load > En).
//
// Ports:
//   Clk      in  1          rising-edge clock
//   Rst      in  1          synchronous reset, active-low
//   Clr      in  1          clear count to 0
//   Load     in  1          load LoadVal into count
//   LoadVal  in  DATAWIDTH  load value
//   En       in  1          count enable
//   Dir      in  1          1 = up, 0 = down
//   Step     in  STEPWIDTH  unsigned step magnitude
//   OvfClr   in  1          clear sticky ovf
//   d        out DATAWIDTH  registered count
//   tc       out 1          terminal count for the current direction
//   ovf      out 1          sticky carry/borrow flag
module inc_step_counter
  import inc_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int STEPWIDTH = 4,
  parameter int SATURATE  = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Clr,
  input  logic                 Load,
  input  logic [DATAWIDTH-1:0] LoadVal,
  input  logic                 En,
  input  logic                 Dir,
  input  logic [STEPWIDTH-1:0] Step,
  input  logic                 OvfClr,
  output logic [DATAWIDTH-1:0] d,
  output logic                 tc,
  output logic                 ovf
);

  localparam logic [DATAWIDTH-1:0] ONES = DATAWIDTH'(all_ones(DATAWIDTH));

  logic [DATAWIDTH-1:0] alu_r;
  logic                 alu_evt;
  logic [DATAWIDTH-1:0] step_next;

  inc_step_alu #(
    .DATAWIDTH (DATAWIDTH),
    .STEPWIDTH (STEPWIDTH)
  ) u_alu (
    .a    (d),
    .step (Step),
    .dir  (Dir),
    .r    (alu_r),
    .evt  (alu_evt)
  );

  // On a carry/borrow, saturate mode pins the count to the boundary in the
  // direction of travel; wrap mode simply keeps the truncated result.
  always_comb begin
    step_next = alu_r;
    if (alu_evt && (SATURATE == MODE_SAT)) begin
      step_next = (Dir == DIR_UP) ? ONES : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      d   <= '0;
      ovf <= 1'b0;
    end else begin
      if (OvfClr) begin
        ovf <= 1'b0;
      end
      if (Clr) begin
        d <= '0;
      end else if (Load) begin
        d <= LoadVal;
      end else if (En) begin
        d <= step_next;
        // Later assignment wins: a fresh event beats a coincident OvfClr.
        if (alu_evt) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign tc = (Dir == DIR_UP) ? (d == ONES) : (d == '0);

endmodule

// File: tb/tb_inc_step_counter.sv
module tb_inc_step_counter;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       load;
  logic [7:0] loadval;
  logic       en;
  logic       dir;
  logic [3:0] step;
  logic       ovfclr;

  logic [7:0] d_w, d_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  inc_step_counter #(.DATAWIDTH(8), .STEPWIDTH(4), .SATURATE(0)) u_wrap (
    .Clk(clk), .Rst(rst), .Clr(clr), .Load(load), .LoadVal(loadval),
    .En(en), .Dir(dir), .Step(step), .OvfClr(ovfclr),
    .d(d_w), .tc(tc_w), .ovf(ovf_w)
  );

  inc_step_counter #(.DATAWIDTH(8), .STEPWIDTH(4), .SATURATE(1)) u_sat (
    .Clk(clk), .Rst(rst), .Clr(clr), .Load(load), .LoadVal(loadval),
    .En(en), .Dir(dir), .Step(step), .OvfClr(ovfclr),
    .d(d_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       dir;
    logic [3:0] step;
    logic       ovfclr;
    logic [7:0] dw;
    logic       ow;
    logic [7:0] ds;
    logic       os;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic tc_of(input logic [7:0] v, input logic dr);
    return dr ? (v == 8'hFF) : (v == 8'h00);
  endfunction

  task automatic drive(input logic c, input logic l, input logic [7:0] lv,
                       input logic e, input logic dr, input logic [3:0] s,
                       input logic oc);
    clr = c; load = l; loadval = lv; en = e; dir = dr; step = s; ovfclr = oc;
  endtask

  task automatic check_both(input string nm, input logic [7:0] dw, input logic ow,
                            input logic [7:0] ds, input logic os);
    chk({nm, " wrap d"},   d_w,         dw);
    chk({nm, " wrap ovf"}, {7'd0, ovf_w}, {7'd0, ow});
    chk({nm, " wrap tc"},  {7'd0, tc_w},  {7'd0, tc_of(dw, dir)});
    chk({nm, " sat d"},    d_s,         ds);
    chk({nm, " sat ovf"},  {7'd0, ovf_s}, {7'd0, os});
    chk({nm, " sat tc"},   {7'd0, tc_s},  {7'd0, tc_of(ds, dir)});
  endtask

  initial begin
    //              name            clr load lv     en dir step  oc  dw     ow  ds     os
    vecs[0]  = '{"load_fe",        0, 1, 8'hFE, 0, 1, 4'd0, 0, 8'hFE, 0, 8'hFE, 0};
    vecs[1]  = '{"up3_carry",      0, 0, 8'h00, 1, 1, 4'd3, 0, 8'h01, 1, 8'hFF, 1};
    vecs[2]  = '{"ovfclr",         0, 0, 8'h00, 0, 1, 4'd0, 1, 8'h01, 0, 8'hFF, 0};
    vecs[3]  = '{"load_02",        0, 1, 8'h02, 0, 0, 4'd0, 0, 8'h02, 0, 8'h02, 0};
    vecs[4]  = '{"dn5_borrow",     0, 0, 8'h00, 1, 0, 4'd5, 0, 8'hFD, 1, 8'h00, 1};
    vecs[5]  = '{"load_fc",        0, 1, 8'hFC, 0, 1, 4'd0, 0, 8'hFC, 1, 8'hFC, 1};
    vecs[6]  = '{"up3_exact_ff",   0, 0, 8'h00, 1, 1, 4'd3, 0, 8'hFF, 1, 8'hFF, 1};
    vecs[7]  = '{"clr_beats_load", 1, 1, 8'h55, 1, 1, 4'd3, 0, 8'h00, 1, 8'h00, 1};
    vecs[8]  = '{"load_beats_en",  0, 1, 8'h55, 1, 1, 4'd3, 0, 8'h55, 1, 8'h55, 1};
    vecs[9]  = '{"ovfclr2",        0, 0, 8'h00, 0, 1, 4'd0, 1, 8'h55, 0, 8'h55, 0};
    vecs[10] = '{"step0_up",       0, 0, 8'h00, 1, 1, 4'd0, 0, 8'h55, 0, 8'h55, 0};
    vecs[11] = '{"step0_dn",       0, 0, 8'h00, 1, 0, 4'd0, 0, 8'h55, 0, 8'h55, 0};
    vecs[12] = '{"load_f0",        0, 1, 8'hF0, 0, 1, 4'd0, 0, 8'hF0, 0, 8'hF0, 0};
    vecs[13] = '{"up15_to_ff",     0, 0, 8'h00, 1, 1, 4'd15, 0, 8'hFF, 0, 8'hFF, 0};
    vecs[14] = '{"evt_and_ovfclr", 0, 0, 8'h00, 1, 1, 4'd1, 1, 8'h00, 1, 8'hFF, 1};
    vecs[15] = '{"dn1",            0, 0, 8'h00, 1, 0, 4'd1, 0, 8'hFF, 1, 8'hFE, 1};
    vecs[16] = '{"ovfclr3",        0, 0, 8'h00, 0, 0, 4'd0, 1, 8'hFF, 0, 8'hFE, 0};
    vecs[17] = '{"hold_dir_dn",    0, 0, 8'h00, 0, 0, 4'd7, 0, 8'hFF, 0, 8'hFE, 0};
    vecs[18] = '{"dn4",            0, 0, 8'h00, 1, 0, 4'd4, 0, 8'hFB, 0, 8'hFA, 0};

    // Reset: held low for two edges, counting inputs active to show they are ignored.
    rst = 1'b0;
    drive(0, 1, 8'h99, 1, 0, 4'd3, 0);
    repeat (2) @(posedge clk);
    #1;
    check_both("reset_dn", 8'h00, 0, 8'h00, 0);
    dir = 1'b1;
    #1;
    check_both("reset_up", 8'h00, 0, 8'h00, 0);

    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 8'h00, 0, 1, 4'd0, 0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].en,
            vecs[i].dir, vecs[i].step, vecs[i].ovfclr);
      @(posedge clk);
      #1;
      check_both(vecs[i].name, vecs[i].dw, vecs[i].ow, vecs[i].ds, vecs[i].os);
    end

    // tc follows Dir with no clock edge: both counts sit at FB/FA, neither terminal;
    // load FF then flip Dir down to see tc drop without an edge.
    @(negedge clk);
    drive(0, 1, 8'hFF, 0, 1, 4'd0, 0);
    @(posedge clk);
    #1;
    check_both("load_ff_up", 8'hFF, 0, 8'hFF, 0);
    dir = 1'b0;
    #1;
    check_both("dir_flip_dn", 8'hFF, 0, 8'hFF, 0);

    // Set ovf, then count up by 1 from 0x10 and reset mid-count with Load asserted.
    @(negedge clk);
    drive(0, 0, 8'h00, 1, 1, 4'd1, 0);
    @(posedge clk);
    #1;
    check_both("ff_plus1", 8'h00, 1, 8'hFF, 1);
    @(negedge clk);
    drive(0, 1, 8'h10, 0, 1, 4'd1, 0);
    @(posedge clk);
    #1;
    check_both("load_10", 8'h10, 1, 8'h10, 1);
    @(negedge clk);
    drive(0, 0, 8'h00, 1, 1, 4'd1, 0);
    @(posedge clk);
    #1;
    check_both("cnt_11", 8'h11, 1, 8'h11, 1);
    @(posedge clk);
    #1;
    check_both("cnt_12", 8'h12, 1, 8'h12, 1);

    // Inputs change between edges: d must not move until the next edge.
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 8'hAA, 1, 1, 4'd1, 0);
    #1;
    check_both("no_comb_path", 8'h12, 1, 8'h12, 1);
    @(posedge clk);
    #1;
    check_both("reset_midcount", 8'h00, 0, 8'h00, 0);

    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 8'h00, 1, 1, 4'd1, 0);
    @(posedge clk);
    #1;
    check_both("after_reset_cnt", 8'h01, 0, 8'h01, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
